pipeline_stall_ctrl: RTL and testbench

Hazard sequencing controller for the 5-stage RISC-V pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use dependencies, taken-branch squashes, and multi-cycle data-memory accesses. It drives per-stage stall and flush enables to the pipeline registers, runs a memory-wait FSM with a timeout watchdog, and keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Hazard sequencing controller for the 5-stage RISC-V pipeline: load-use stalls,
// taken-branch squashes, a memory-wait FSM with timeout watchdog, and perf counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERROR
  } state_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       mem_stall;
  logic       lw_hz;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      S_IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_next    = S_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      S_WAIT: begin
        // A late ack wins over the watchdog, even on the final allowed cycle.
        if (MemAckM) begin
          state_next    = S_IDLE;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_next = S_ERROR;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      S_ERROR: state_next = S_ERROR;
      default: begin
        state_next    = S_IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Mealy term on the IDLE miss so the first miss cycle is already held.
  assign mem_stall = ((state == S_IDLE) && MemReqM && !MemAckM)
                   || (state == S_WAIT) || (state == S_ERROR);

  assign lw_hz = MemReadE && (RD_E != 5'd0)
              && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // Squashing D also removes the consumer of any load-use hazard.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_hz) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == S_ERROR) begin
        mem_err <= 1'b1;
      end
      if (StallF && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (FlushD && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares. A CNT_W=4 twin covers saturation.
module tb_pipeline_stall_ctrl;

  localparam logic [6:0] H_NONE = 7'b0000000;
  localparam logic [6:0] H_MEM  = 7'b1111001;
  localparam logic [6:0] H_BR   = 7'b0000110;
  localparam logic [6:0] H_LW   = 7'b1100010;

  typedef struct packed {
    logic [6:0]  hz;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadE, PCSrcE, MemReqM, MemAckM;
  logic [4:0]  RD_E, Rs1_D, Rs2_D;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_mem_err;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [6:0]  act_hz;
  logic        err_m;
  logic [15:0] sc_m, fc_m;
  logic [3:0]  sc4_m, fc4_m;
  int          tests_run = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_stall_ctrl #(.CNT_W(4), .MEM_TIMEOUT(15)) u_sat (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
    .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e  = sb.pop_front();
      act_hz = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
      tests_run++;
      if (act_hz !== mon_e.hz || mem_err !== mon_e.err || stall_cnt !== mon_e.sc ||
          flush_cnt !== mon_e.fc || s_stall_cnt !== mon_e.sc4 || s_flush_cnt !== mon_e.fc4 ||
          {s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW} !== mon_e.hz) begin
        fails++;
        $display("FAIL sb @%0t: got hz=%b err=%b sc=%0d fc=%0d sc4=%0d fc4=%0d, want hz=%b err=%b sc=%0d fc=%0d sc4=%0d fc4=%0d",
                 $time, act_hz, mem_err, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                 mon_e.hz, mon_e.err, mon_e.sc, mon_e.fc, mon_e.sc4, mon_e.fc4);
      end
    end
  end

  // Drive one cycle, push its expectation, then advance the reference counters/flag.
  task automatic drive(input logic mre, input logic [4:0] rde, input logic [4:0] r1,
                       input logic [4:0] r2, input logic br, input logic req,
                       input logic ack, input logic rs, input logic [6:0] hz,
                       input logic enter_err);
    exp_t e;
    MemReadE = mre; RD_E = rde; Rs1_D = r1; Rs2_D = r2;
    PCSrcE = br; MemReqM = req; MemAckM = ack; rst = rs;
    e.hz = hz; e.err = err_m; e.sc = sc_m; e.fc = fc_m; e.sc4 = sc4_m; e.fc4 = fc4_m;
    sb.push_back(e);
    if (rs) begin
      err_m = 1'b0; sc_m = '0; fc_m = '0; sc4_m = '0; fc4_m = '0;
    end else begin
      if (hz[6]) begin
        if (sc_m != 16'hFFFF) sc_m = sc_m + 16'd1;
        if (sc4_m != 4'hF) sc4_m = sc4_m + 4'd1;
      end
      if (hz[2]) begin
        if (fc_m != 16'hFFFF) fc_m = fc_m + 16'd1;
        if (fc4_m != 4'hF) fc4_m = fc4_m + 4'd1;
      end
      if (enter_err) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, H_NONE, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, H_NONE, 0);
  endtask

  task automatic test_reset();
    // Hazard inputs active during reset must not leak to outputs.
    rst = 1'b1; MemReadE = 1'b1; RD_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd0;
    PCSrcE = 1'b1; MemReqM = 1'b1; MemAckM = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    tests_run++;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got err=%b sc=%0d fc=%0d want 0 0 0", mem_err, stall_cnt, flush_cnt);
    end
    @(posedge clk);
    #1;
    err_m = 1'b0; sc_m = '0; fc_m = '0; sc4_m = '0; fc4_m = '0;
    idle(2);
  endtask

  task automatic test_load_use();
    drive(1, 5, 0, 5, 0, 0, 0, 0, H_LW, 0);
    idle(1);
    tests_run++;
    if (stall_cnt !== 16'd1) begin
      fails++;
      $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    drive(1, 7, 7, 3, 0, 0, 0, 0, H_LW, 0);
    drive(1, 5, 3, 4, 0, 0, 0, 0, H_NONE, 0);
    drive(0, 5, 5, 5, 0, 0, 0, 0, H_NONE, 0);
    idle(1);
  endtask

  task automatic test_load_x0();
    drive(1, 0, 0, 0, 0, 0, 0, 0, H_NONE, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, H_NONE, 0);
  endtask

  task automatic test_branch_lw();
    do_reset();
    drive(1, 5, 0, 5, 1, 0, 0, 0, H_BR, 0);
    idle(1);
    tests_run++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL branch_lw_cnt: got fc=%0d sc=%0d want 1 0", flush_cnt, stall_cnt);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, H_BR, 0);
  endtask

  task automatic test_mem_ack3();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(1, 5, 0, 5, 1, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_MEM, 0);
    idle(1);
    tests_run++;
    if (stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
      fails++;
      $display("FAIL mem_ack3_cnt: got sc=%0d fc=%0d want 4 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_same_cycle_ack();
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_NONE, 0);
    drive(1, 9, 9, 0, 0, 1, 1, 0, H_LW, 0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_MEM, 0);
    idle(1);
  endtask

  task automatic test_ack_at_timeout();
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    for (int i = 1; i < 15; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_MEM, 0);
    idle(1);
    tests_run++;
    if (mem_err !== 1'b0) begin
      fails++;
      $display("FAIL ack_at_timeout_err: got %b want 0", mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    for (int i = 1; i < 15; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 1);
    drive(0, 0, 0, 0, 0, 1, 1, 0, H_MEM, 0);
    drive(1, 5, 5, 0, 1, 0, 1, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, H_MEM, 0);
    tests_run++;
    if (mem_err !== 1'b1 || stall_cnt !== 16'd19 || s_stall_cnt !== 4'd15) begin
      fails++;
      $display("FAIL timeout_err: got err=%b sc=%0d sc4=%0d want 1 19 15", mem_err, stall_cnt, s_stall_cnt);
    end
    do_reset();
    idle(1);
    tests_run++;
    if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      fails++;
      $display("FAIL timeout_reset: got err=%b sc=%0d fc=%0d want 0 0 0", mem_err, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1, 5, 0, 5, 0, 0, 0, 0, H_LW, 0);
    idle(1);
    tests_run++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      fails++;
      $display("FAIL saturation: got sc4=%0d sc=%0d want 15 20", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, H_MEM, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1, H_NONE, 0);
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    err_m = 1'b0; sc_m = '0; fc_m = '0; sc4_m = '0; fc4_m = '0;
    test_reset();
    test_load_use();
    test_load_x0();
    test_branch_lw();
    test_mem_ack3();
    test_same_cycle_ack();
    test_back_to_back();
    test_ack_at_timeout();
    test_timeout();
    test_saturation();
    test_reset_in_wait();
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
